// File: rtl/apb_pkg.sv
// Shared types and widths for the APB request bridge.
package apb_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam int PROT_W = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

endpackage

// File: rtl/apb_wdog.sv
// ACCESS-phase watchdog for apb_req_bridge; only present when APB_TIMEOUT_EN is defined.
`ifdef APB_TIMEOUT_EN
module apb_wdog #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic resetn,
   input  logic start,
   input  logic clear,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

   logic [CW-1:0] r_count;

   // Counts completed ACCESS cycles; expire fires during the last permitted one.
   always_ff @(posedge clk) begin
      if (!resetn || clear) begin
         r_count <= '0;
      end else if (start && !expire) begin
         r_count <= r_count + CW'(1);
      end
   end

   assign expire = start && (r_count == CW'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/apb_req_bridge.sv
// Valid/ready command to APB requester bridge with registered outputs.
// Optional ACCESS watchdog enabled by defining APB_TIMEOUT_EN.
module apb_req_bridge
   import apb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   input  logic [PROT_W-1:0] cmd_prot,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] pwdata,
   output logic [PROT_W-1:0] prot,
   input  logic              pready,
   input  logic              pslverr,
   input  logic [DATA_W-1:0] prdata
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("apb_req_bridge: TIMEOUT_CYCLES must be at least 1");
   end

   apb_state_e r_state;
   apb_state_e w_next_state;

   logic              r_cmd_ready;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic              r_rsp_err;
   logic              r_psel;
   logic              r_penable;
   logic              r_pwrite;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_pwdata;
   logic [PROT_W-1:0] r_prot;

   logic w_accept;
   logic w_in_access;
   logic w_expire;
   logic w_psel_d;
   logic w_penable_d;
   logic w_cmd_ready_d;
   logic w_rsp_valid_d;

   assign w_accept    = cmd_valid && r_cmd_ready;
   assign w_in_access = (r_state == ACCESS);

`ifdef APB_TIMEOUT_EN
   apb_wdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wdog (
      .clk    (clk),
      .resetn (resetn),
      .start  (w_in_access),
      .clear  (!w_in_access),
      .expire (w_expire)
   );
`else
   assign w_expire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next_state = SETUP;
         SETUP:   w_next_state = ACCESS;
         ACCESS:  if (pready || w_expire) w_next_state = RESP;
         RESP:    if (rsp_ready) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Control outputs are decoded from the next state so they register in step with it.
   always_comb begin
      w_psel_d      = (w_next_state == SETUP) || (w_next_state == ACCESS);
      w_penable_d   = (w_next_state == ACCESS);
      w_cmd_ready_d = (w_next_state == IDLE);
      w_rsp_valid_d = (w_next_state == RESP);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_cmd_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
         r_pwrite    <= 1'b0;
         r_addr      <= '0;
         r_pwdata    <= '0;
         r_prot      <= '0;
      end else begin
         r_cmd_ready <= w_cmd_ready_d;
         r_rsp_valid <= w_rsp_valid_d;
         r_psel      <= w_psel_d;
         r_penable   <= w_penable_d;
         if (w_accept) begin
            r_pwrite <= cmd_write;
            r_addr   <= cmd_addr;
            r_prot   <= cmd_prot;
            r_pwdata <= cmd_write ? cmd_wdata : '0;
         end
         // Completer response only matters in ACCESS; a real pready beats the watchdog.
         if (w_in_access) begin
            if (pready) begin
               r_rsp_rdata <= r_pwrite ? '0 : prdata;
               r_rsp_err   <= pslverr;
            end else if (w_expire) begin
               r_rsp_rdata <= '0;
               r_rsp_err   <= 1'b1;
            end
         end
      end
   end

   assign cmd_ready = r_cmd_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign psel      = r_psel;
   assign penable   = r_penable;
   assign pwrite    = r_pwrite;
   assign addr      = r_addr;
   assign pwdata    = r_pwdata;
   assign prot      = r_prot;

endmodule

// File: tb/tb_apb_req_bridge.sv
// Directed, table-driven bench for apb_req_bridge with a small APB completer model.
// Covers the watchdog path when APB_TIMEOUT_EN is defined, indefinite waits otherwise.
module tb_apb_req_bridge;

   localparam int TimeoutCycles = 16;

   logic        clk;
   logic        resetn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [4:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic [2:0]  cmd_prot;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [4:0]  addr;
   logic [31:0] pwdata;
   logic [2:0]  prot;
   logic        pready;
   logic        pslverr;
   logic [31:0] prdata;

   int testsRun = 0;
   int failCount = 0;

   typedef struct {
      logic        write;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [2:0]  prot;
      int          waits;
      logic [31:0] prdata;
      logic        pslverr;
      int          rspDelay;
      logic [31:0] expPwdata;
      logic [31:0] expRdata;
      logic        expErr;
   } vec_t;

   vec_t vecs[6];

   apb_req_bridge #(
      .TIMEOUT_CYCLES(TimeoutCycles)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .cmd_prot  (cmd_prot),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .addr      (addr),
      .pwdata    (pwdata),
      .prot      (prot),
      .pready    (pready),
      .pslverr   (pslverr),
      .prdata    (prdata)
   );

   // Free-running 10 ns clock; stimulus and sampling both happen on the falling edge.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_ctrl"}, {31'd0, cmd_ready} | {27'd0, psel, penable, pwrite, rsp_valid, rsp_err} << 1, 32'd1);
      checkOutput({tag, "_addr_prot"}, {24'd0, addr, prot}, 32'd0);
      checkOutput({tag, "_pwdata"}, pwdata, 32'd0);
      checkOutput({tag, "_rdata"}, rsp_rdata, 32'd0);
   endtask

   // One full command: accept, SETUP, ACCESS with wait states, RESP with backpressure.
   task automatic applyStimulus(input vec_t v, input int idx);
      string tag;
      int edges;
      int busCycles;
      int waitCnt;
      int guard;
      bit done;
      tag = $sformatf("v%0d", idx);
      @(negedge clk);
      checkOutput({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_write = v.write;
      cmd_addr  = v.addr;
      cmd_wdata = v.wdata;
      cmd_prot  = v.prot;
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_addr  = ~v.addr;
      cmd_wdata = ~v.wdata;
      cmd_prot  = ~v.prot;
      checkOutput({tag, "_setup_ctrl"}, {29'd0, psel, penable, cmd_ready}, 32'b100);
      checkOutput({tag, "_setup_addr_prot"}, {23'd0, pwrite, addr, prot}, {23'd0, v.write, v.addr, v.prot});
      checkOutput({tag, "_setup_pwdata"}, pwdata, v.expPwdata);
      pready    = 1'b1;
      pslverr   = 1'b1;
      prdata    = 32'hBAD0_BAD0;
      rsp_ready = 1'b1;
      busCycles = 1;
      @(posedge clk);
      edges++;
      waitCnt = 0;
      guard   = 0;
      done    = 1'b0;
      while (!done && guard < 200) begin
         @(negedge clk);
         guard++;
         if (rsp_valid) begin
            done = 1'b1;
         end else begin
            busCycles++;
            checkOutput({tag, "_access_ctrl"}, {30'd0, psel, penable}, 32'b11);
            checkOutput({tag, "_access_addr_prot"}, {23'd0, pwrite, addr, prot}, {23'd0, v.write, v.addr, v.prot});
            checkOutput({tag, "_access_pwdata"}, pwdata, v.expPwdata);
            rsp_ready = 1'b0;
            cmd_valid = 1'b1;
            pready    = (waitCnt == v.waits);
            pslverr   = (waitCnt == v.waits) ? v.pslverr : 1'b0;
            prdata    = (waitCnt == v.waits) ? v.prdata : 32'hBAD0_BAD0;
            waitCnt++;
            @(posedge clk);
            edges++;
         end
      end
      if (!done) checkOutput({tag, "_rsp_wait_bound"}, 32'd0, 32'd1);
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = 32'h0;
      checkOutput({tag, "_latency"}, edges, 3 + v.waits);
      checkOutput({tag, "_bus_cycles"}, busCycles, 2 + v.waits);
      checkOutput({tag, "_resp_ctrl"}, {29'd0, psel, penable, cmd_ready}, 32'd0);
      checkOutput({tag, "_rdata"}, rsp_rdata, v.expRdata);
      checkOutput({tag, "_err"}, {31'd0, rsp_err}, {31'd0, v.expErr});
      for (int i = 0; i < v.rspDelay; i++) begin
         @(negedge clk);
         checkOutput({tag, "_hold"}, {30'd0, rsp_valid, cmd_ready}, 32'b10);
         checkOutput({tag, "_hold_rdata"}, rsp_rdata, v.expRdata);
         checkOutput({tag, "_hold_err"}, {31'd0, rsp_err}, {31'd0, v.expErr});
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checkOutput({tag, "_done"}, {29'd0, rsp_valid, psel, cmd_ready}, 32'b001);
   endtask

   // Starts a read and returns once the bridge is in ACCESS with pready held low.
   task automatic startStalledRead(input logic [4:0] a);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = a;
      cmd_prot  = 3'b000;
      cmd_wdata = 32'h0;
      pready    = 1'b0;
      prdata    = 32'hFEED_FACE;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      checkOutput("stall_in_access", {30'd0, psel, penable}, 32'b11);
   endtask

   initial begin
      int accessCycles;
      bit stillWaiting;
      resetn    = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      cmd_prot  = '0;
      rsp_ready = 1'b0;
      pready    = 1'b0;
      pslverr   = 1'b0;
      prdata    = '0;

      vecs[0] = '{1'b1, 5'd1,  32'hDEAD_BEEF, 3'b000, 0, 32'h5555_5555, 1'b0, 0, 32'hDEAD_BEEF, 32'h0,         1'b0};
      vecs[1] = '{1'b0, 5'd1,  32'hCAFE_F00D, 3'b010, 3, 32'h1234_5678, 1'b0, 1, 32'h0,         32'h1234_5678, 1'b0};
      vecs[2] = '{1'b0, 5'd31, 32'h0,         3'b111, 0, 32'hA5A5_A5A5, 1'b1, 4, 32'h0,         32'hA5A5_A5A5, 1'b1};
      vecs[3] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 3'b100, 2, 32'h7777_7777, 1'b1, 0, 32'hFFFF_FFFF, 32'h0,         1'b1};
      vecs[4] = '{1'b1, 5'd16, 32'h0000_0001, 3'b001, 1, 32'h0,         1'b0, 2, 32'h0000_0001, 32'h0,         1'b0};
      vecs[5] = '{1'b0, 5'd10, 32'h1357_9BDF, 3'b000, 0, 32'h0,         1'b0, 0, 32'h0,         32'h0,         1'b0};

      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      checkIdleOutputs("reset");

      for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

      // Reset in the middle of ACCESS must drop the bus and lose the response.
      startStalledRead(5'd7);
      resetn = 1'b0;
      @(negedge clk);
      checkOutput("midrst_bus", {29'd0, psel, penable, rsp_valid}, 32'd0);
      resetn  = 1'b1;
      pready  = 1'b1;
      pslverr = 1'b1;
      @(negedge clk);
      checkIdleOutputs("midrst_release");
      @(negedge clk);
      checkOutput("midrst_no_rsp", {30'd0, rsp_valid, cmd_ready}, 32'b01);
      pready  = 1'b0;
      pslverr = 1'b0;

`ifdef APB_TIMEOUT_EN
      // Completer never answers: the watchdog ends the transfer with an error.
      startStalledRead(5'd3);
      accessCycles = 1;
      for (int i = 0; i < 100 && !rsp_valid; i++) begin
         @(negedge clk);
         if (penable) accessCycles++;
      end
      checkOutput("wdog_access_cycles", accessCycles, TimeoutCycles);
      checkOutput("wdog_resp", {29'd0, rsp_valid, psel, penable}, 32'b100);
      checkOutput("wdog_err", {31'd0, rsp_err}, 32'd1);
      checkOutput("wdog_rdata", rsp_rdata, 32'd0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checkOutput("wdog_done", {30'd0, rsp_valid, cmd_ready}, 32'b01);
`else
      // Without the watchdog a silent completer stalls ACCESS for as long as it likes.
      startStalledRead(5'd3);
      stillWaiting = 1'b1;
      for (int i = 0; i < 3 * TimeoutCycles; i++) begin
         @(negedge clk);
         if (!(psel && penable) || rsp_valid) stillWaiting = 1'b0;
      end
      checkOutput("nowdog_still_access", {31'd0, stillWaiting}, 32'd1);
      pready = 1'b1;
      prdata = 32'h0BAD_F00D;
      @(negedge clk);
      pready = 1'b0;
      checkOutput("nowdog_resp", {29'd0, rsp_valid, psel, rsp_err}, 32'b100);
      checkOutput("nowdog_rdata", rsp_rdata, 32'h0BAD_F00D);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checkOutput("nowdog_done", {30'd0, rsp_valid, cmd_ready}, 32'b01);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
